fifo_match_queue: RTL and testbench
===================================

// Module: fifo_match_queue
// PURPOSE
//  Parametrised circular FIFO with content match: the successor to the plain/valid-tracking buffers.
//  Supports any depth, with all BUFF_DEPTH entries usable, plus an exposed occupancy count and almost_full.
//  Adds synchronous flush and MATCH_PORTS independent tag-match ports that return the youngest matching entry.
//  Sits between issue and memory stages as a store/miss queue: hazard detection plus store-to-load forwarding.
// PARAMETERS
//  DATA_WIDTH   32  entry payload width
//  TAG_WIDTH    32  low TAG_WIDTH bits of an entry are its match tag; TAG_WIDTH <= DATA_WIDTH
//  BUFF_DEPTH   4   number of entries; any value >= 2, power of two not required
//  ADDR_WIDTH   2   pointer width = clog2(BUFF_DEPTH)
//  MATCH_PORTS  2   number of independent match ports, >= 1
//  AFULL_THRESH 3   almost_full asserts when count >= AFULL_THRESH; 1..BUFF_DEPTH
// PORTS
//  clk          in   1                         single clock, rising edge
//  resetn       in   1                         asynchronous, active-low reset
//  flush        in   1                         discard all entries (synchronous)
//  wen          in   1                         write request
//  input_data   in   DATA_WIDTH                write payload
//  ren          in   1                         read (pop) request
//  output_data  out  DATA_WIDTH                oldest entry (buff[tail]); 0 when empty
//  empty        out  1                         count == 0
//  full         out  1                         count == BUFF_DEPTH
//  almost_full  out  1                         count >= AFULL_THRESH
//  count        out  ADDR_WIDTH+1              number of valid entries
//  match_tag    in   MATCH_PORTS*TAG_WIDTH     port p uses bits [p*TAG_WIDTH +: TAG_WIDTH]
//  match_hit    out  MATCH_PORTS               port p matches at least one valid entry
//  match_data   out  MATCH_PORTS*DATA_WIDTH    payload of the youngest match on port p; 0 if no hit
// BEHAVIOUR
//  Reset (async, while resetn=0): head=tail=0, count=0, all valid=0, all entries=0.
//   Resulting outputs: empty=1, full=0, almost_full=0, output_data=0, match_hit=0, match_data=0.
//  Accept rules: do_write = wen & !full & !flush; do_read = ren & !empty & !flush. Both use registered flags.
//   Write at full is dropped, even if a read happens in the same cycle.
//   Read at empty is ignored, even if a write happens in the same cycle. No fall-through.
//  Count update:
//   do_write & !do_read -> count+1
//   do_read & !do_write -> count-1
//   both -> count unchanged
//  Write: entry[head] <= input_data, valid[head] <= 1.
//  Read: entry[tail] <= 0, valid[tail] <= 0.
//  Pointers advance by 1 and wrap from BUFF_DEPTH-1 to 0 explicitly; no modulo-2^N wrap.
//  Latency: a written value is visible on output_data the cycle after the write when the FIFO was empty.
//   output_data is combinational from tail; a read moves to the next entry at the next edge.
//  Flush (sync): next edge head=tail=count=0 and all valid/entries cleared. Overrides wen/ren in the same cycle.
//  Match (combinational) on port p: hit_vec[i] = valid[i] & (entry[i][TAG_WIDTH-1:0] == tag_p).
//   The entry being written this cycle is not visible to match.
//   The entry being read this cycle is still matched.
//   Youngest = the hit at the largest age k, where index = (tail+k) wrapped and k < count.
//   match_data is that entry's payload, or 0 if there is no hit.
//  almost_full and full are derived from the registered count only.
//  Reset mid-operation: contents are discarded immediately; there is no partial-state retention.
// STRUCTURE
//  Shared package fifo_pkg: clog2 function and ptr_inc(ptr, depth) wrap function.
//   The queue layer's count-width constant also lives in fifo_pkg.
//  One sub-module fifo_youngest_sel (valid vector, tail, hit vector -> one-hot youngest index).
//   It rotates by tail, runs a priority search from the top, then rotates back.
//   Instantiated once per match port via generate.
// TESTING (bench: DEPTH=4, TAG_WIDTH=8, DATA_WIDTH=16, AFULL_THRESH=3)
//  1 Assert resetn=0 mid-cycle with 3 entries held.
//    -> empty=1, count=0, match_hit=0 immediately, before the next edge.
//  2 Write 0x0A,0x0B,0x0C,0x0D.
//    -> almost_full after the 3rd write, full=1 and count=4 after the 4th.
//    -> A 5th write of 0x0E is dropped; reads return 0A,0B,0C,0D, then empty=1 and output_data=0.
//  3 Write 3, read 2, write 3 (pointer wrap).
//    -> Order is preserved across the wrap; count=4, full=1.
//  4 Simultaneous wen & ren:
//    -> at count=2: count stays 2
//    -> at empty: count becomes 1, read ignored
//    -> at full: count becomes 3, write dropped
//  5 Hold entries 0x1110, 0x2220, 0x3310; port0 tag=0x10, port1 tag=0x30.
//    -> hit=2'b01, match_data0=0x3310.
//    -> Writing 0x4410 in the same cycle does not change data0 until the next cycle, where it becomes 0x4410.
//  6 flush=1 with wen=1 and count=3.
//    -> Next cycle: empty=1, count=0, match_hit=0, write dropped.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer-width math and explicit pointer wrap.
package fifo_pkg;

    // Extra count bit so the occupancy can reach BUFF_DEPTH itself.
    localparam int unsigned COUNT_PAD = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r++;
        return r;
    endfunction

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_youngest_sel.sv
// Picks the youngest hit of a circular buffer as a one-hot index vector.
module fifo_youngest_sel #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-1:0]    tail,
    input  logic [DEPTH-1:0] hit,
    output logic [DEPTH-1:0] sel
);

    logic [DEPTH-1:0] rot;
    logic [DEPTH-1:0] rot_sel;
    logic             found;

    function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return AW'(s);
    endfunction

    // Age-order view: bit k is the entry k places after tail.
    always_comb begin
        rot = '0;
        for (int unsigned k = 0; k < DEPTH; k++)
            rot[k] = hit[wrap_idx(tail, k)] & valid[wrap_idx(tail, k)];
    end

    always_comb begin
        rot_sel = '0;
        found   = 1'b0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (!found && rot[k]) begin
                rot_sel[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int unsigned k = 0; k < DEPTH; k++)
            sel[wrap_idx(tail, k)] = rot_sel[k];
    end

endmodule

// File: rtl/fifo_match_queue.sv
// Circular store/miss queue with occupancy flags, flush and youngest-entry tag match ports.
module fifo_match_queue
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH    = 32,
    parameter int unsigned BUFF_DEPTH   = 4,
    parameter int unsigned ADDR_WIDTH   = clog2(BUFF_DEPTH),
    parameter int unsigned MATCH_PORTS  = 2,
    parameter int unsigned AFULL_THRESH = 3
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              flush,
    input  logic                              wen,
    input  logic [DATA_WIDTH-1:0]             input_data,
    input  logic                              ren,
    output logic [DATA_WIDTH-1:0]             output_data,
    output logic                              empty,
    output logic                              full,
    output logic                              almost_full,
    output logic [ADDR_WIDTH:0]               count,
    input  logic [MATCH_PORTS*TAG_WIDTH-1:0]  match_tag,
    output logic [MATCH_PORTS-1:0]            match_hit,
    output logic [MATCH_PORTS*DATA_WIDTH-1:0] match_data
);

    localparam int unsigned CW = ADDR_WIDTH + COUNT_PAD;

    logic [DATA_WIDTH-1:0] entry [BUFF_DEPTH];
    logic [BUFF_DEPTH-1:0] valid;
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [CW-1:0]         count_q;
    logic                  do_write;
    logic                  do_read;

    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(BUFF_DEPTH));
    assign almost_full = (count_q >= CW'(AFULL_THRESH));
    assign do_write    = wen & ~full & ~flush;
    assign do_read     = ren & ~empty & ~flush;
    assign output_data = empty ? '0 : entry[tail];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            valid   <= '0;
            for (int unsigned i = 0; i < BUFF_DEPTH; i++) entry[i] <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            valid   <= '0;
            for (int unsigned i = 0; i < BUFF_DEPTH; i++) entry[i] <= '0;
        end else begin
            // Read and write never share an index: that needs empty or full.
            if (do_read) begin
                entry[tail] <= '0;
                valid[tail] <= 1'b0;
                tail        <= ADDR_WIDTH'(ptr_inc(32'(tail), BUFF_DEPTH));
            end
            if (do_write) begin
                entry[head] <= input_data;
                valid[head] <= 1'b1;
                head        <= ADDR_WIDTH'(ptr_inc(32'(head), BUFF_DEPTH));
            end
            if (do_write && !do_read)
                count_q <= count_q + CW'(1);
            else if (do_read && !do_write)
                count_q <= count_q - CW'(1);
        end
    end

    for (genvar p = 0; p < MATCH_PORTS; p++) begin : g_port
        logic [TAG_WIDTH-1:0]  tag;
        logic [BUFF_DEPTH-1:0] hit_vec;
        logic [BUFF_DEPTH-1:0] sel;
        logic [DATA_WIDTH-1:0] data;

        assign tag = match_tag[p*TAG_WIDTH +: TAG_WIDTH];

        always_comb begin
            hit_vec = '0;
            for (int unsigned i = 0; i < BUFF_DEPTH; i++)
                hit_vec[i] = valid[i] & (entry[i][TAG_WIDTH-1:0] == tag);
        end

        fifo_youngest_sel #(
            .DEPTH (BUFF_DEPTH),
            .AW    (ADDR_WIDTH)
        ) u_sel (
            .valid (valid),
            .tail  (tail),
            .hit   (hit_vec),
            .sel   (sel)
        );

        always_comb begin
            data = '0;
            for (int unsigned i = 0; i < BUFF_DEPTH; i++)
                if (sel[i]) data = data | entry[i];
        end

        assign match_hit[p]                           = |hit_vec;
        assign match_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    end

endmodule

// File: tb/tb_fifo_match_queue.sv
// Bench for fifo_match_queue: occupancy vector table, read-data scoreboard, match/flush/reset sequences.
module tb_fifo_match_queue;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        wen;
    logic [15:0] input_data;
    logic        ren;
    logic [15:0] output_data;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [2:0]  count;
    logic [15:0] match_tag;
    logic [1:0]  match_hit;
    logic [31:0] match_data;

    fifo_match_queue #(
        .DATA_WIDTH   (16),
        .TAG_WIDTH    (8),
        .BUFF_DEPTH   (4),
        .ADDR_WIDTH   (2),
        .MATCH_PORTS  (2),
        .AFULL_THRESH (3)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .wen         (wen),
        .input_data  (input_data),
        .ren         (ren),
        .output_data (output_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .match_tag   (match_tag),
        .match_hit   (match_hit),
        .match_data  (match_data)
    );

    typedef struct {
        logic        wen;
        logic        ren;
        logic [15:0] data;
        int unsigned cnt;
        logic        full;
        logic        af;
        logic        emp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; the scoreboard decides acceptance from its own occupancy.
    task automatic drive(input logic w, input logic r, input logic [15:0] d, input logic fl);
        bit was_full;
        bit was_empty;
        wen        = w;
        ren        = r;
        input_data = d;
        flush      = fl;
        was_full   = (sb.size() == 4);
        was_empty  = (sb.size() == 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (r && !was_empty) check("rd_data", 32'(output_data), 32'(sb.pop_front()));
            if (w && !was_full) sb.push_back(d);
        end
    endtask

    task automatic add(input logic w, input logic r, input logic [15:0] d, input int unsigned c,
                       input logic f, input logic a, input logic e);
        vecs.push_back('{w, r, d, c, f, a, e});
    endtask

    initial begin
        resetn     = 1'b0;
        flush      = 1'b0;
        wen        = 1'b0;
        ren        = 1'b0;
        input_data = '0;
        match_tag  = '0;

        // fill, overflow drop, drain
        add(1, 0, 16'h000A, 1, 0, 0, 0);
        add(1, 0, 16'h000B, 2, 0, 0, 0);
        add(1, 0, 16'h000C, 3, 0, 1, 0);
        add(1, 0, 16'h000D, 4, 1, 1, 0);
        add(1, 0, 16'h000E, 4, 1, 1, 0);
        add(0, 1, 16'h0000, 3, 0, 1, 0);
        add(0, 1, 16'h0000, 2, 0, 0, 0);
        add(0, 1, 16'h0000, 1, 0, 0, 0);
        add(0, 1, 16'h0000, 0, 0, 0, 1);
        // pointer wrap
        add(1, 0, 16'h0011, 1, 0, 0, 0);
        add(1, 0, 16'h0012, 2, 0, 0, 0);
        add(1, 0, 16'h0013, 3, 0, 1, 0);
        add(0, 1, 16'h0000, 2, 0, 0, 0);
        add(0, 1, 16'h0000, 1, 0, 0, 0);
        add(1, 0, 16'h0014, 2, 0, 0, 0);
        add(1, 0, 16'h0015, 3, 0, 1, 0);
        add(1, 0, 16'h0016, 4, 1, 1, 0);
        add(0, 1, 16'h0000, 3, 0, 1, 0);
        add(0, 1, 16'h0000, 2, 0, 0, 0);
        add(0, 1, 16'h0000, 1, 0, 0, 0);
        add(0, 1, 16'h0000, 0, 0, 0, 1);
        // simultaneous read/write at count 2, empty and full
        add(1, 0, 16'h0021, 1, 0, 0, 0);
        add(1, 0, 16'h0022, 2, 0, 0, 0);
        add(1, 1, 16'h0023, 2, 0, 0, 0);
        add(0, 1, 16'h0000, 1, 0, 0, 0);
        add(0, 1, 16'h0000, 0, 0, 0, 1);
        add(1, 1, 16'h0024, 1, 0, 0, 0);
        add(1, 0, 16'h0025, 2, 0, 0, 0);
        add(1, 0, 16'h0026, 3, 0, 1, 0);
        add(1, 0, 16'h0027, 4, 1, 1, 0);
        add(1, 1, 16'h0028, 3, 0, 1, 0);
        add(0, 1, 16'h0000, 2, 0, 0, 0);
        add(0, 1, 16'h0000, 1, 0, 0, 0);
        add(0, 1, 16'h0000, 0, 0, 0, 1);

        #12;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out", 32'(output_data), 32'd0);
        check("rst_hit", 32'(match_hit), 32'd0);
        check("rst_mdata", match_data, 32'd0);
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].wen, vecs[i].ren, vecs[i].data, 1'b0);
            tick();
            check($sformatf("count[%0d]", i), 32'(count), vecs[i].cnt);
            check($sformatf("full[%0d]", i), 32'(full), 32'(vecs[i].full));
            check($sformatf("afull[%0d]", i), 32'(almost_full), 32'(vecs[i].af));
            check($sformatf("empty[%0d]", i), 32'(empty), 32'(vecs[i].emp));
        end
        drive(0, 0, 16'h0000, 0);
        check("empty_out", 32'(output_data), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // youngest match across a wrapped buffer
        drive(1, 0, 16'h1110, 0); tick();
        drive(1, 0, 16'h2220, 0); tick();
        drive(1, 0, 16'h3310, 0); tick();
        drive(0, 0, 16'h0000, 0);
        match_tag = {8'h30, 8'h10};
        #1;
        check("m_hit", 32'(match_hit), 32'h1);
        check("m_data0", 32'(match_data[15:0]), 32'h3310);
        check("m_data1", 32'(match_data[31:16]), 32'h0);
        drive(1, 0, 16'h4410, 0);
        #1;
        check("m_data0_same_cycle", 32'(match_data[15:0]), 32'h3310);
        tick();
        drive(0, 0, 16'h0000, 0);
        check("m_data0_next", 32'(match_data[15:0]), 32'h4410);
        check("m_hit_next", 32'(match_hit), 32'h1);
        check("m_count", 32'(count), 32'd4);

        // flush with a competing write at count 3
        drive(0, 1, 16'h0000, 0); tick();
        check("pre_flush_count", 32'(count), 32'd3);
        drive(1, 0, 16'h5510, 1); tick();
        drive(0, 0, 16'h0000, 0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_count", 32'(count), 32'd0);
        check("fl_hit", 32'(match_hit), 32'd0);
        check("fl_out", 32'(output_data), 32'd0);
        tick();
        check("fl_count_after", 32'(count), 32'd0);

        // asynchronous reset with entries held
        drive(1, 0, 16'h0A10, 0); tick();
        drive(1, 0, 16'h0B10, 0); tick();
        drive(1, 0, 16'h0C10, 0); tick();
        drive(0, 0, 16'h0000, 0);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_hit", 32'(match_hit), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        sb.delete();
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_count", 32'(count), 32'd0);
        check("arst_hit", 32'(match_hit), 32'd0);
        check("arst_mdata", match_data, 32'd0);
        check("arst_out", 32'(output_data), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
